// File: rtl/weight_recover_mc.sv
// Per-band row-carry store for the CCSDS-123 predictor: captures the weight vector at
// each row end and replays it at the next row start of the same band (fixed 3-cycle read).
module weight_recover_mc #(
  parameter int X_LEN   = 11,
  parameter int Y_LEN   = 5,
  parameter int Z_LEN   = 8,
  parameter int W_WIDTH = 19,
  parameter int NUM_W   = 3,
  parameter logic [W_WIDTH-1:0] INI_DATA = {W_WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_load_i,
  input  logic [X_LEN-1:0]           Nx,
  input  logic [Y_LEN-1:0]           Ny,
  input  logic [Z_LEN-1:0]           Nz,
  input  logic                       carry_mode_i,
  input  logic                       w_valid_i,
  input  logic [NUM_W*W_WIDTH-1:0]   w_data_i,
  input  logic                       r_valid_i,
  output logic [NUM_W*W_WIDTH-1:0]   rec_data_o,
  output logic                       rec_valid_o,
  output logic                       cfg_err_o
);

  localparam int DW    = NUM_W * W_WIDTH;
  localparam int DEPTH = 2 ** Z_LEN;
  localparam logic [X_LEN-1:0] X_ONE = {{(X_LEN-1){1'b0}}, 1'b1};
  localparam logic [Y_LEN-1:0] Y_ONE = {{(Y_LEN-1){1'b0}}, 1'b1};
  localparam logic [Z_LEN-1:0] Z_ONE = {{(Z_LEN-1){1'b0}}, 1'b1};
  localparam logic [X_LEN-1:0] X_ZERO = {X_LEN{1'b0}};
  localparam logic [Y_LEN-1:0] Y_ZERO = {Y_LEN{1'b0}};
  localparam logic [Z_LEN-1:0] Z_ZERO = {Z_LEN{1'b0}};
  localparam logic [DW-1:0]    D_ZERO = {DW{1'b0}};

  logic [X_LEN-1:0] nx_r, wx_r, rx_r;
  logic [Y_LEN-1:0] ny_r, wy_r, ry_r;
  logic [Z_LEN-1:0] nz_r, wz_r, rz_r;
  logic             carry_r;

  logic             wr_vld_r;
  logic [Z_LEN-1:0] wr_z_r;
  logic [DW-1:0]    wr_data_r;

  logic             s1_vld_r, s1_y0_r;
  logic [Z_LEN-1:0] s1_z_r;
  logic             s2_vld_r, s2_y0_r, s2_flag_r;
  logic [DW-1:0]    s2_data_r;

  logic [DW-1:0]    store_r [DEPTH];
  logic [DEPTH-1:0] flag_r;

  logic w_x_last_s, w_z_last_s, w_y_last_s;
  logic r_x_last_s, r_z_last_s, r_y_last_s;
  logic idle_s, cfg_ok_s, rd_hit_s, rd_flag_s;
  logic [DW-1:0] rd_data_s;

  // Wrap detection, idle qualification and write-first store read
  always_comb begin
    w_x_last_s = (wx_r == nx_r - X_ONE);
    w_z_last_s = (wz_r == nz_r - Z_ONE);
    w_y_last_s = (wy_r == ny_r - Y_ONE);
    r_x_last_s = (rx_r == nx_r - X_ONE);
    r_z_last_s = (rz_r == nz_r - Z_ONE);
    r_y_last_s = (ry_r == ny_r - Y_ONE);
    idle_s = (wx_r == X_ZERO) && (wz_r == Z_ZERO) && (wy_r == Y_ZERO) &&
             (rx_r == X_ZERO) && (rz_r == Z_ZERO) && (ry_r == Y_ZERO) &&
             !wr_vld_r && !s1_vld_r && !s2_vld_r && !rec_valid_o;
    cfg_ok_s  = cfg_load_i && idle_s;
    rd_hit_s  = wr_vld_r && (wr_z_r == s1_z_r);
    rd_flag_s = rd_hit_s || flag_r[s1_z_r];
    if (rd_hit_s) begin
      rd_data_s = wr_data_r;
    end else begin
      rd_data_s = store_r[s1_z_r];
    end
  end

  // Frame geometry and carry mode, loaded only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nx_r      <= X_ZERO;
      ny_r      <= Y_ZERO;
      nz_r      <= Z_ZERO;
      carry_r   <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= cfg_load_i && !idle_s;
      if (cfg_ok_s) begin
        nx_r    <= Nx;
        ny_r    <= Ny;
        nz_r    <= Nz;
        carry_r <= carry_mode_i;
      end
    end
  end

  // Write and read position counters (x fastest, then z, then y)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx_r <= X_ZERO; wz_r <= Z_ZERO; wy_r <= Y_ZERO;
      rx_r <= X_ZERO; rz_r <= Z_ZERO; ry_r <= Y_ZERO;
    end else if (cfg_ok_s) begin
      wx_r <= X_ZERO; wz_r <= Z_ZERO; wy_r <= Y_ZERO;
      rx_r <= X_ZERO; rz_r <= Z_ZERO; ry_r <= Y_ZERO;
    end else begin
      if (w_valid_i) begin
        if (w_x_last_s) begin
          wx_r <= X_ZERO;
          if (w_z_last_s) begin
            wz_r <= Z_ZERO;
            wy_r <= w_y_last_s ? Y_ZERO : wy_r + Y_ONE;
          end else begin
            wz_r <= wz_r + Z_ONE;
          end
        end else begin
          wx_r <= wx_r + X_ONE;
        end
      end
      if (r_valid_i) begin
        if (r_x_last_s) begin
          rx_r <= X_ZERO;
          if (r_z_last_s) begin
            rz_r <= Z_ZERO;
            ry_r <= r_y_last_s ? Y_ZERO : ry_r + Y_ONE;
          end else begin
            rz_r <= rz_r + Z_ONE;
          end
        end else begin
          rx_r <= rx_r + X_ONE;
        end
      end
    end
  end

  // Row-end capture register and per-band valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_r  <= 1'b0;
      wr_z_r    <= Z_ZERO;
      wr_data_r <= D_ZERO;
      flag_r    <= {DEPTH{1'b0}};
    end else begin
      wr_vld_r <= w_valid_i && w_x_last_s;
      if (w_valid_i && w_x_last_s) begin
        wr_z_r    <= wz_r;
        wr_data_r <= w_data_i;
      end
      if (wr_vld_r) begin
        flag_r[wr_z_r] <= 1'b1;
      end
    end
  end

  // Weight store; contents are meaningless until the band flag is set
  always_ff @(posedge clk) begin
    if (wr_vld_r) begin
      store_r[wr_z_r] <= wr_data_r;
    end
  end

  // Read pipeline: request, store read, output select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r    <= 1'b0;
      s1_y0_r     <= 1'b0;
      s1_z_r      <= Z_ZERO;
      s2_vld_r    <= 1'b0;
      s2_y0_r     <= 1'b0;
      s2_flag_r   <= 1'b0;
      s2_data_r   <= D_ZERO;
      rec_valid_o <= 1'b0;
      rec_data_o  <= D_ZERO;
    end else begin
      s1_vld_r    <= r_valid_i && (rx_r == X_ZERO);
      s1_y0_r     <= (ry_r == Y_ZERO);
      s1_z_r      <= rz_r;
      s2_vld_r    <= s1_vld_r;
      s2_y0_r     <= s1_y0_r;
      s2_flag_r   <= rd_flag_s;
      s2_data_r   <= rd_data_s;
      rec_valid_o <= s2_vld_r;
      if (!s2_vld_r) begin
        rec_data_o <= D_ZERO;
      end else if (!s2_y0_r || (carry_r && s2_flag_r)) begin
        rec_data_o <= s2_data_r;
      end else begin
        rec_data_o <= {NUM_W{INI_DATA}};
      end
    end
  end

endmodule

// File: tb/tb_weight_recover_mc.sv
// Directed bench for weight_recover_mc: frame tables built from an index-based model,
// plus hand sequences for config rejection, Nx=Nz=1 and mid-frame reset.
module tb_weight_recover_mc;

  localparam int DW = 57;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_load_i = 1'b0;
  logic [10:0]     Nx = 11'd0;
  logic [4:0]      Ny = 5'd0;
  logic [7:0]      Nz = 8'd0;
  logic            carry_mode_i = 1'b0;
  logic            w_valid_i = 1'b0;
  logic [DW-1:0]   w_data_i = '0;
  logic            r_valid_i = 1'b0;
  logic [DW-1:0]   rec_data_o;
  logic            rec_valid_o;
  logic            cfg_err_o;

  weight_recover_mc dut (
    .clk(clk), .rst_n(rst_n), .cfg_load_i(cfg_load_i), .Nx(Nx), .Ny(Ny), .Nz(Nz),
    .carry_mode_i(carry_mode_i), .w_valid_i(w_valid_i), .w_data_i(w_data_i),
    .r_valid_i(r_valid_i), .rec_data_o(rec_data_o), .rec_valid_o(rec_valid_o),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic          wv;
    logic [DW-1:0] wd;
    logic          ev;
    logic          dc;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t          tbl [0:63];
  logic [DW-1:0] m_store [0:3];
  bit            m_flag [0:3];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Write data for write-stream index i of a frame; a few indices carry named vectors
  function automatic logic [DW-1:0] wdata(input int seed, input int i);
    logic [18:0] a, b, c;
    if (seed == 0 && i == 3) begin
      a = 19'h11; b = 19'h22; c = 19'h33;
    end else if (seed == 0 && i == 7) begin
      a = 19'h44; b = 19'h55; c = 19'h66;
    end else if (seed == 2 && i == 23) begin
      a = 19'h7; b = 19'h8; c = 19'h9;
    end else begin
      a = 19'(seed * 4096 + i + 1);
      b = 19'(seed * 4096 + i + 257);
      c = 19'(seed * 4096 + i + 513);
    end
    return {a, b, c};
  endfunction

  task automatic cfg(input int nx, input int ny, input int nz, input bit cm);
    @(posedge clk); #1;
    Nx = 11'(nx); Ny = 5'(ny); Nz = 8'(nz); carry_mode_i = cm; cfg_load_i = 1'b1;
    @(posedge clk); #1;
    cfg_load_i = 1'b0;
    Nx = 11'd5; Ny = 5'd9; Nz = 8'd3; carry_mode_i = ~cm;
    chk("cfg_err_idle", 64'(cfg_err_o), 64'(1'b0));
  endtask

  // One full frame: reads start at rd_off, writes at wr_off (cycle offsets)
  task automatic run_frame(input int seed, input int nx, input int ny, input int nz,
                           input bit carry, input int rd_off, input int wr_off, input bit do_w);
    int f, n, ri, wi, y, z;
    logic ev, dc;
    logic [DW-1:0] ed;
    f = nx * ny * nz;
    n = f + ((rd_off > wr_off) ? rd_off : wr_off);
    for (int c = 0; c < n; c++) begin
      tbl[c] = '{rv: 1'b0, wv: 1'b0, wd: '0, ev: 1'b0, dc: 1'b0, ed: '0};
      ri = c - rd_off;
      wi = c - wr_off;
      if (ri >= 0 && ri < f) begin
        tbl[c].rv = 1'b1;
        if (ri % nx == 0) begin
          tbl[c].ev = 1'b1;
          y = ri / (nx * nz);
          z = (ri / nx) % nz;
          if (y > 0) begin
            if (do_w) tbl[c].ed = wdata(seed, (y - 1) * nx * nz + z * nx + nx - 1);
            else tbl[c].dc = 1'b1;
          end else if (carry && m_flag[z]) begin
            tbl[c].ed = m_store[z];
          end
        end
      end
      if (do_w && wi >= 0 && wi < f) begin
        tbl[c].wv = 1'b1;
        tbl[c].wd = wdata(seed, wi);
      end
    end
    for (int c = 0; c < n + 3; c++) begin
      @(posedge clk); #1;
      ev = 1'b0; dc = 1'b0; ed = '0;
      if (c >= 3) begin
        ev = tbl[c-3].ev; dc = tbl[c-3].dc; ed = tbl[c-3].ed;
      end
      chk($sformatf("s%0d_valid_c%0d", seed, c), 64'(rec_valid_o), 64'(ev));
      if (!dc) chk($sformatf("s%0d_data_c%0d", seed, c), 64'(rec_data_o), 64'(ed));
      if (c < n) begin
        r_valid_i = tbl[c].rv; w_valid_i = tbl[c].wv; w_data_i = tbl[c].wd;
      end else begin
        r_valid_i = 1'b0; w_valid_i = 1'b0; w_data_i = '0;
      end
    end
    if (do_w) begin
      for (int zz = 0; zz < nz; zz++) begin
        m_store[zz] = wdata(seed, (ny - 1) * nx * nz + zz * nx + nx - 1);
        m_flag[zz] = 1'b1;
      end
    end
  endtask

  initial begin
    int vcnt;
    for (int i = 0; i < 4; i++) begin
      m_store[i] = '0;
      m_flag[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rec_valid_o), 64'(1'b0));
    chk("rst_data", 64'(rec_data_o), 64'(0));
    chk("rst_cfg_err", 64'(cfg_err_o), 64'(1'b0));
    rst_n = 1'b1;

    // Reads only: row-0 starts give INI, rows 1-2 data unknown
    cfg(4, 3, 2, 0);
    run_frame(100, 4, 3, 2, 1'b0, 0, 0, 1'b0);
    // Row-end writes replayed on the next row
    run_frame(0, 4, 3, 2, 1'b0, 0, 0, 1'b1);
    // Reads lead writes by 5 so every replay collides with its own write
    run_frame(1, 4, 3, 2, 1'b0, 0, 5, 1'b1);
    // Carry mode: band 1 ends with 7/8/9 and is carried into the next frame
    cfg(4, 3, 2, 1);
    run_frame(2, 4, 3, 2, 1'b1, 0, 0, 1'b1);
    chk("carry_model", 64'(m_store[1]), 64'({19'h7, 19'h8, 19'h9}));
    run_frame(3, 4, 3, 2, 1'b1, 0, 0, 1'b1);
    cfg(4, 3, 2, 0);
    run_frame(4, 4, 3, 2, 1'b0, 0, 0, 1'b1);

    // Mid-frame load is rejected and the old geometry stays in force
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      vcnt += int'(rec_valid_o);
      if (c == 3) chk("cfg_err_pulse", 64'(cfg_err_o), 64'(1'b1));
      if (c == 4) chk("cfg_err_once", 64'(cfg_err_o), 64'(1'b0));
      cfg_load_i = (c == 2);
      if (c == 2) begin
        Nx = 11'd1; Ny = 5'd1; Nz = 8'd1;
      end
      r_valid_i = (c != 2) && (c < 25);
    end
    chk("cfg_keep_count", 64'(vcnt), 64'(6));

    // Nx=Ny=Nz=1: every read sample is a row start
    cfg(1, 1, 1, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("n1_valid_c%0d", c), 64'(rec_valid_o), 64'(c >= 3 && c <= 8));
      chk($sformatf("n1_data_c%0d", c), 64'(rec_data_o), 64'(0));
      r_valid_i = (c < 6);
    end

    // Reset in mid-frame clears output at once and drops the band flags
    cfg(4, 3, 2, 1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 7) chk("pre_rst_valid", 64'(rec_valid_o), 64'(1'b1));
      r_valid_i = (c < 5);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(rec_valid_o), 64'(1'b0));
    chk("midrst_data", 64'(rec_data_o), 64'(0));
    for (int i = 0; i < 4; i++) m_flag[i] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg(4, 3, 2, 1);
    run_frame(5, 4, 3, 2, 1'b1, 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
